cache_mem_arbiter: RTL and testbench

- Shares the single memory read port between the icache and the dcache, and sequences the dcache's single-entry write path.
- Sits between both caches and the cache-to-AXI bridge.
- Grants one read burst at a time and steers the returned beats to the requester that owns the burst, tagging each beat with its index.
- Blocks any dcache read whose line address matches a write that is still outstanding (read-after-write hazard).

---
 rtl/cache_mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the shared memory read port between icache and dcache, steers
// returned beats to the burst owner, and tracks the dcache's single outstanding write.
module cache_mem_arbiter #(
   parameter int LINE_BEATS = 8,
   parameter int LINE_OFF   = 5,
   parameter int STARVE_MAX = 2,
   localparam int BW = $clog2(LINE_BEATS),
   localparam int SW = $clog2(STARVE_MAX + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ic_rreq,
   input  logic [31:0]   ic_raddr,
   input  logic          ic_uc,
   input  logic          dc_rreq,
   input  logic [31:0]   dc_raddr,
   input  logic          dc_uc,
   input  logic          dc_wreq,
   input  logic [31:0]   dc_waddr,
   output logic          ic_rgnt,
   output logic          dc_rgnt,
   output logic          ic_rvalid,
   output logic          dc_rvalid,
   output logic [BW-1:0] r_beat,
   output logic          r_last,
   output logic [31:0]   r_data,
   output logic          dc_wgnt,
   output logic          dc_write_ok,
   output logic          mem_rreq,
   output logic [31:0]   mem_raddr,
   output logic [BW-1:0] mem_rlen,
   input  logic          mem_rgnt,
   input  logic          mem_rvalid,
   input  logic [31:0]   mem_rdata,
   input  logic          mem_rlast,
   output logic          mem_wreq,
   output logic [31:0]   mem_waddr,
   input  logic          mem_wgnt,
   input  logic          mem_wdone,
   output logic          burst_err
);

   typedef enum logic [1:0] {S_IDLE, S_RADDR, S_RDATA} state_t;

   state_t               state_q, state_d;
   logic                 owner_dc_q, owner_dc_d;
   logic                 uc_q, uc_d;
   logic [31:0]          addr_q, addr_d;
   logic [SW-1:0]        starve_q, starve_d;
   logic [BW-1:0]        beat_q, beat_d;
   logic                 err_q, err_d;
   logic                 wbusy_q, wbusy_d;
   logic [31:LINE_OFF]   wline_q, wline_d;

   logic                 dc_elig;
   logic                 ic_turn;
   logic [BW-1:0]        cur_len;

   always_comb begin
      state_d    = state_q;
      owner_dc_d = owner_dc_q;
      uc_d       = uc_q;
      addr_d     = addr_q;
      starve_d   = starve_q;
      beat_d     = beat_q;
      err_d      = err_q;
      wbusy_d    = wbusy_q;
      wline_d    = wline_q;

      ic_rgnt    = 1'b0;
      dc_rgnt    = 1'b0;
      ic_rvalid  = 1'b0;
      dc_rvalid  = 1'b0;
      r_beat     = '0;
      r_last     = 1'b0;
      r_data     = '0;
      mem_rreq   = 1'b0;
      mem_raddr  = '0;
      mem_rlen   = '0;

      // A dcache read to the line of the outstanding write must wait for its completion.
      dc_elig = dc_rreq && !(wbusy_q && (dc_raddr[31:LINE_OFF] == wline_q));
      ic_turn = ic_rreq && (starve_q == SW'(STARVE_MAX));
      cur_len = uc_q ? '0 : BW'(LINE_BEATS - 1);

      case (state_q)
         S_IDLE: begin
            if (ic_turn || (ic_rreq && !dc_elig)) begin
               owner_dc_d = 1'b0;
               uc_d       = ic_uc;
               addr_d     = ic_raddr;
               starve_d   = '0;
               state_d    = S_RADDR;
            end else if (dc_elig) begin
               owner_dc_d = 1'b1;
               uc_d       = dc_uc;
               addr_d     = dc_raddr;
               if (ic_rreq) begin
                  starve_d = starve_q + SW'(1);
               end
               state_d    = S_RADDR;
            end
         end
         S_RADDR: begin
            mem_rreq  = 1'b1;
            mem_raddr = uc_q ? addr_q : {addr_q[31:LINE_OFF], {LINE_OFF{1'b0}}};
            mem_rlen  = cur_len;
            if (mem_rgnt) begin
               ic_rgnt = !owner_dc_q;
               dc_rgnt = owner_dc_q;
               beat_d  = '0;
               state_d = S_RDATA;
            end
         end
         S_RDATA: begin
            if (mem_rvalid) begin
               ic_rvalid = !owner_dc_q;
               dc_rvalid = owner_dc_q;
               r_data    = mem_rdata;
               r_beat    = beat_q;
               r_last    = mem_rlast;
               beat_d    = beat_q + BW'(1);
               if (mem_rlast) begin
                  state_d = S_IDLE;
                  if (beat_q != cur_len) begin
                     err_d = 1'b1;
                  end
               end else if (beat_q == BW'(LINE_BEATS - 1)) begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      mem_wreq    = dc_wreq && !wbusy_q;
      mem_waddr   = mem_wreq ? dc_waddr : '0;
      dc_wgnt     = mem_wreq && mem_wgnt;
      dc_write_ok = !wbusy_q;
      // Completion is applied first so a same-cycle new grant leaves the tracker busy.
      if (mem_wdone) begin
         wbusy_d = 1'b0;
      end
      if (dc_wgnt) begin
         wbusy_d = 1'b1;
         wline_d = dc_waddr[31:LINE_OFF];
      end

      burst_err = err_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         owner_dc_q <= 1'b0;
         uc_q       <= 1'b0;
         addr_q     <= '0;
         starve_q   <= '0;
         beat_q     <= '0;
         err_q      <= 1'b0;
         wbusy_q    <= 1'b0;
         wline_q    <= '0;
      end else begin
         state_q    <= state_d;
         owner_dc_q <= owner_dc_d;
         uc_q       <= uc_d;
         addr_q     <= addr_d;
         starve_q   <= starve_d;
         beat_q     <= beat_d;
         err_q      <= err_d;
         wbusy_q    <= wbusy_d;
         wline_q    <= wline_d;
      end
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized bench for cache_mem_arbiter: a transaction-level model predicts the
// winner of each arbitration, the memory request, every returned beat and the error flag.
module tb_cache_mem_arbiter;

   localparam int STARVE_MAX = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ic_rreq = 1'b0, ic_uc = 1'b0, dc_rreq = 1'b0, dc_uc = 1'b0, dc_wreq = 1'b0;
   logic [31:0] ic_raddr = '0, dc_raddr = '0, dc_waddr = '0;
   logic        ic_rgnt, dc_rgnt, ic_rvalid, dc_rvalid, r_last, dc_wgnt, dc_write_ok;
   logic [2:0]  r_beat, mem_rlen;
   logic [31:0] r_data, mem_raddr, mem_waddr;
   logic        mem_rreq, mem_wreq, burst_err;
   logic        mem_rgnt = 1'b0, mem_rvalid = 1'b0, mem_rlast = 1'b0, mem_wgnt = 1'b0, mem_wdone = 1'b0;
   logic [31:0] mem_rdata = '0;

   cache_mem_arbiter #(.LINE_BEATS(8), .LINE_OFF(5), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .ic_rreq(ic_rreq), .ic_raddr(ic_raddr), .ic_uc(ic_uc),
      .dc_rreq(dc_rreq), .dc_raddr(dc_raddr), .dc_uc(dc_uc),
      .dc_wreq(dc_wreq), .dc_waddr(dc_waddr),
      .ic_rgnt(ic_rgnt), .dc_rgnt(dc_rgnt), .ic_rvalid(ic_rvalid), .dc_rvalid(dc_rvalid),
      .r_beat(r_beat), .r_last(r_last), .r_data(r_data),
      .dc_wgnt(dc_wgnt), .dc_write_ok(dc_write_ok),
      .mem_rreq(mem_rreq), .mem_raddr(mem_raddr), .mem_rlen(mem_rlen),
      .mem_rgnt(mem_rgnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast),
      .mem_wreq(mem_wreq), .mem_waddr(mem_waddr), .mem_wgnt(mem_wgnt), .mem_wdone(mem_wdone),
      .burst_err(burst_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   bit          ic_pend = 0, dc_pend = 0, ic_u = 0, dc_u = 0;
   logic [31:0] ic_a = '0, dc_a = '0, w_a = '0;
   int          starve = 0;
   bit          err_exp = 0, w_busy = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic raise_ic(input logic [31:0] a, input bit u);
      ic_pend = 1; ic_a = a; ic_u = u;
      ic_rreq = 1'b1; ic_raddr = a; ic_uc = u;
   endtask

   task automatic raise_dc(input logic [31:0] a, input bit u);
      dc_pend = 1; dc_a = a; dc_u = u;
      dc_rreq = 1'b1; dc_raddr = a; dc_uc = u;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_ctl"}, {ic_rgnt, dc_rgnt, ic_rvalid, dc_rvalid, r_beat, r_last, dc_wgnt,
                              mem_rreq, mem_rlen, mem_wreq, burst_err, dc_write_ok}, 32'd1);
      check_eq({tag, "_rdata"}, r_data, 32'd0);
      check_eq({tag, "_raddr"}, mem_raddr | mem_waddr, 32'd0);
   endtask

   // Entered at a falling edge with requests already raised; leaves at a falling edge.
   task automatic do_burst(input int gdly, input int last_at, input int abort_at);
      bit          seen, win_ic, dc_ok, u;
      logic [31:0] ea, d;
      int          n, last;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (mem_rreq) begin seen = 1; break; end
         @(negedge clk);
      end
      if (!seen) begin
         check_eq("rreq_timeout", 32'd0, 32'd1);
         return;
      end
      dc_ok  = dc_pend && !(w_busy && (dc_a[31:5] == w_a[31:5]));
      win_ic = ic_pend && ((starve == STARVE_MAX) || !dc_ok);
      if (win_ic) starve = 0;
      else if (ic_pend) starve++;
      u  = win_ic ? ic_u : dc_u;
      ea = win_ic ? ic_a : dc_a;
      if (!u) ea[4:0] = 5'd0;
      n    = u ? 1 : 8;
      last = (last_at >= 0) ? last_at : n - 1;
      check_eq("mem_raddr", mem_raddr, ea);
      check_eq("mem_rlen", mem_rlen, n - 1);
      repeat (gdly) begin
         @(negedge clk); #1;
         check_eq("rgnt_early", {ic_rgnt, dc_rgnt}, 32'd0);
      end
      mem_rgnt = 1'b1; #1;
      check_eq("ic_rgnt", ic_rgnt, win_ic);
      check_eq("dc_rgnt", dc_rgnt, !win_ic);
      @(negedge clk);
      mem_rgnt = 1'b0;
      if (win_ic) begin ic_rreq = 1'b0; ic_pend = 0; end
      else begin dc_rreq = 1'b0; dc_pend = 0; end
      for (int i = 0; i <= last; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            mem_rvalid = 1'b0; #1;
            check_eq("rvalid_gap", {ic_rvalid, dc_rvalid}, 32'd0);
            @(negedge clk);
         end
         d = $urandom;
         mem_rvalid = 1'b1; mem_rdata = d; mem_rlast = (i == last);
         if (i == abort_at) begin
            rst_n = 1'b0;
            @(negedge clk);
            mem_rlast = 1'b0;
            starve = 0; err_exp = 0; w_busy = 0;
            #1;
            check_reset_outputs("rst_mid");
            $display("[TB] burst aborted by reset at beat %0d", i);
            return;
         end
         #1;
         check_eq("ic_rvalid", ic_rvalid, win_ic);
         check_eq("dc_rvalid", dc_rvalid, !win_ic);
         check_eq("r_beat", r_beat, i);
         check_eq("r_data", r_data, d);
         check_eq("r_last", r_last, (i == last));
         @(negedge clk);
      end
      mem_rvalid = 1'b0; mem_rlast = 1'b0;
      if (last != n - 1) err_exp = 1;
      #1;
      check_eq("burst_err", burst_err, err_exp);
      $display("[TB] burst owner=%s addr=%08h beats=%0d err=%0d", win_ic ? "ic" : "dc", ea, last + 1, err_exp);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("rst_init");
      rst_n = 1'b1;
      @(negedge clk);

      // Cached icache fetch with a two-cycle address acceptance delay
      raise_ic(32'h1FC0_0024, 0);
      do_burst(2, -1, -1);

      // Both requesters held high: starvation limit forces periodic icache wins
      raise_ic(32'h0040_0000, 0);
      raise_dc(32'h1000_0000, 0);
      for (int t = 0; t < 6; t++) begin
         do_burst($urandom_range(0, 3), -1, -1);
         if (!ic_pend) raise_ic(32'h0040_0000 + 32'(t) * 32'h20, 0);
         if (!dc_pend) raise_dc(32'h1000_0000 + 32'(t) * 32'h20, 0);
      end
      do_burst(0, -1, -1);
      do_burst(0, -1, -1);

      // Uncached dcache read raised together with an icache line fetch
      raise_dc(32'hBFAF_8000, 1);
      raise_ic(32'h1FC0_0100, 0);
      do_burst(1, -1, -1);
      do_burst(1, -1, -1);

      // Read-after-write hazard on line 0x1040
      dc_wreq = 1'b1; dc_waddr = 32'h0000_1040; #1;
      check_eq("mem_wreq", mem_wreq, 32'd1);
      check_eq("mem_waddr", mem_waddr, 32'h0000_1040);
      check_eq("write_ok_idle", dc_write_ok, 32'd1);
      mem_wgnt = 1'b1; #1;
      check_eq("dc_wgnt", dc_wgnt, 32'd1);
      @(negedge clk);
      mem_wgnt = 1'b0; w_busy = 1; w_a = 32'h0000_1040;
      dc_waddr = 32'h0000_2000; #1;
      check_eq("wreq_busy", mem_wreq, 32'd0);
      check_eq("write_ok_busy", dc_write_ok, 32'd0);
      dc_wreq = 1'b0;
      raise_dc(32'h0000_105C, 0);
      raise_ic(32'h2000_0100, 0);
      do_burst(1, -1, -1);
      repeat (3) begin
         #1;
         check_eq("raw_blocked", mem_rreq, 32'd0);
         check_eq("raw_write_ok", dc_write_ok, 32'd0);
         @(negedge clk);
      end
      mem_wdone = 1'b1; #1;
      check_eq("raw_wdone_cycle", mem_rreq, 32'd0);
      @(negedge clk);
      mem_wdone = 1'b0; w_busy = 0;
      #1;
      check_eq("write_ok_done", dc_write_ok, 32'd1);
      do_burst(0, -1, -1);

      // Early mem_rlast on beat 5, then good bursts keep the sticky error
      raise_dc(32'h3000_0040, 0);
      do_burst(0, 5, -1);
      raise_ic(32'h1FC0_0400, 0);
      do_burst(1, -1, -1);

      // Randomized mixed traffic
      for (int t = 0; t < 30; t++) begin
         if (!ic_pend && $urandom_range(0, 1) == 1) raise_ic($urandom, bit'($urandom_range(0, 1)));
         if (!dc_pend && $urandom_range(0, 1) == 1) raise_dc($urandom, bit'($urandom_range(0, 1)));
         if (!ic_pend && !dc_pend) raise_ic($urandom, 0);
         do_burst($urandom_range(0, 3), -1, -1);
      end
      while (ic_pend || dc_pend) do_burst(0, -1, -1);

      // Reset during beat 3; trailing beats must be ignored
      raise_ic(32'h1FC0_0200, 0);
      do_burst(1, -1, 3);
      rst_n = 1'b1;
      for (int i = 5; i < 8; i++) begin
         @(negedge clk);
         mem_rvalid = 1'b1; mem_rlast = (i == 7); mem_rdata = $urandom; #1;
         check_eq("stale_rvalid", {ic_rvalid, dc_rvalid, r_last}, 32'd0);
      end
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rlast = 1'b0; #1;
      check_eq("stale_err", burst_err, 32'd0);
      raise_ic(32'h1FC0_0300, 0);
      do_burst(0, -1, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
